// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin owner selection for a shared 4:1 data mux.
// Four requesters compete. The winner holds the path for a burst of at most
// BURST_LEN accepted beats, or until it withdraws its request. The winner is
// presented as a one-hot grant and as a binary mux select.
// Optional feature: define RR_SEL_ARB_LOCK_EN to add a `lock` input. While
// `lock` is high, the owner keeps the grant past the burst cap.
module rr_sel_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             ready,
`ifdef RR_SEL_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Count value at which the next accepted beat closes the burst.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r, state_s;
    logic [1:0]       last_r, last_s;
    logic [3:0]       gnt_r, gnt_s;
    logic [1:0]       sel_r, sel_s;
    logic             valid_r, valid_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       pick_s;
    logic             lock_hold_s;

    // Scan the requests starting just after the previous winner, so every
    // requester gets a turn. The loop visits last+1, last+2, last+3 and then last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        pick  = l;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = l + k[1:0];
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef RR_SEL_ARB_LOCK_EN
    assign lock_hold_s = lock;
`else
    assign lock_hold_s = 1'b0;
`endif

    assign pick_s = rr_pick(req, last_r);

    // Next-state logic: arbitrate in IDLE, count beats and detect release in GRANT.
    always_comb begin
        state_s = state_r;
        last_s  = last_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        valid_s = valid_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    gnt_s   = 4'b0001 << pick_s;
                    sel_s   = pick_s;
                    valid_s = 1'b1;
                    cnt_s   = '0;
                    state_s = ST_GRANT;
                end else begin
                    gnt_s   = 4'b0000;
                    valid_s = 1'b0;
                    cnt_s   = '0;
                end
            end
            ST_GRANT: begin
                if (!req[sel_r]) begin
                    // The owner has withdrawn. No beat is counted this cycle.
                    last_s  = sel_r;
                    gnt_s   = 4'b0000;
                    valid_s = 1'b0;
                    state_s = ST_IDLE;
                end else if (valid_r && ready) begin
                    if (cnt_r == CNT_LAST) begin
                        if (lock_hold_s) begin
                            // The locked owner stays on the path. The count saturates.
                            cnt_s = cnt_r;
                        end else begin
                            last_s  = sel_r;
                            gnt_s   = 4'b0000;
                            valid_s = 1'b0;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                gnt_s   = 4'b0000;
                valid_s = 1'b0;
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset puts requester 0 first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            last_r  <= 2'b11;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'b00;
            valid_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            last_r  <= last_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            valid_r <= valid_s;
            cnt_r   <= cnt_s;
        end
    end

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign gnt_valid = valid_r;
    assign beat_cnt  = cnt_r;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed scenarios for rr_sel_arbiter.
// The stimulus process queues the expected grants. A monitor checks each grant
// when it starts and when it ends. The lock scenario runs only when
// RR_SEL_ARB_LOCK_EN is defined.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;
`ifdef RR_SEL_ARB_LOCK_EN
    logic       lock;
`endif
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       gnt_valid;
    logic [7:0] beat_cnt;

    rr_sel_arbiter #(.BURST_LEN(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ready     (ready),
`ifdef RR_SEL_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    // Fields: grant, select, high cycles, final beat count, and idle cycles
    // before the grant (-1 means the idle gap is not checked).
    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        int         len;
        int         cnt;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] s, input int len, input int cnt, input int gap);
        exp_t e;
        e.gnt = g;
        e.sel = s;
        e.len = len;
        e.cnt = cnt;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Wait until n grants have ended; returns just after the releasing edge.
    task automatic wait_falls(input int n);
        int   seen   = 0;
        int   budget = 0;
        logic prev;
        prev = gnt_valid;
        while (seen < n && budget < 200) begin
            @(posedge clk);
            #1;
            if (prev && !gnt_valid) seen++;
            prev = gnt_valid;
            budget++;
        end
        if (seen < n) begin
            checks++;
            fails++;
            $display("FAIL wait_release: saw %0d releases, expected %0d", seen, n);
        end
    endtask

    // Monitor state.
    logic       mon_prev = 1'b0;
    int         mon_len  = 0;
    int         mon_low  = 0;
    int         mon_cnt  = 0;
    logic [1:0] mon_sel  = 2'b00;
    logic       mon_live = 1'b0;

    // Monitor: on a rising grant, check the owner and the idle gap; on a
    // falling grant, check the burst length and the final beat count.
    initial begin
        forever begin
            @(negedge clk);
            if (gnt_valid === 1'b1 && !mon_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_grant: gnt=%b sel=%0d", gnt, sel);
                    mon_live = 1'b0;
                end else begin
                    check("grant_gnt", int'(gnt), int'(sb[0].gnt));
                    check("grant_sel", int'(sel), int'(sb[0].sel));
                    if (sb[0].gap >= 0) check("bubble_len", mon_low, sb[0].gap);
                    mon_live = 1'b1;
                end
                mon_len = 0;
                mon_sel = sel;
            end
            if (gnt_valid === 1'b1) begin
                mon_len++;
                mon_cnt = int'(beat_cnt);
                if (sel != mon_sel) check("sel_stable", int'(sel), int'(mon_sel));
            end
            if (gnt_valid !== 1'b1 && mon_prev) begin
                if (mon_live) begin
                    check("grant_len", mon_len, sb[0].len);
                    check("final_beat_cnt", mon_cnt, sb[0].cnt);
                    void'(sb.pop_front());
                end
                mon_live = 1'b0;
                mon_low  = 0;
            end
            if (gnt_valid !== 1'b1) mon_low++;
            mon_prev = (gnt_valid === 1'b1);
        end
    end

    // Stimulus: directed scenarios run in order.
    initial begin
        rst   = 1'b1;
        req   = 4'b1111;
        ready = 1'b1;
`ifdef RR_SEL_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        // Reset held for two cycles with every requester active.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_gnt", int'(gnt), 0);
            check("reset_sel", int'(sel), 0);
            check("reset_gnt_valid", int'(gnt_valid), 0);
            check("reset_beat_cnt", int'(beat_cnt), 0);
        end

        // Full rotation 0,1,2,3,0, with a one-cycle bubble between grants.
        push(4'b0001, 2'd0, 4, 3, -1);
        push(4'b0010, 2'd1, 4, 3, 1);
        push(4'b0100, 2'd2, 4, 3, 1);
        push(4'b1000, 2'd3, 4, 3, 1);
        push(4'b0001, 2'd0, 4, 3, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_falls(5);

        // Grant requester 1 so that last=1, then run sparse 1010: 3,1,3.
        req = 4'b0010;
        push(4'b0010, 2'd1, 4, 3, 1);
        wait_falls(1);
        req = 4'b1010;
        push(4'b1000, 2'd3, 4, 3, 1);
        push(4'b0010, 2'd1, 4, 3, 1);
        push(4'b1000, 2'd3, 4, 3, 1);
        wait_falls(3);
        req = 4'b0000;

        // Requester 2 withdraws after 2 beats; requester 3 is next.
        @(posedge clk);
        #1 req = 4'b0100;
        push(4'b0100, 2'd2, 3, 2, -1);
        push(4'b1000, 2'd3, 4, 3, 1);
        repeat (3) @(posedge clk);
        #1 req = 4'b1011;
        wait_falls(2);
        req = 4'b0000;

        // Back-pressure: ready alternates 0,1. Four beats take 8 cycles.
        @(posedge clk);
        #1;
        ready = 1'b0;
        req   = 4'b0001;
        push(4'b0001, 2'd0, 8, 3, -1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1 ready = (k % 2 == 0);
        end
        wait_falls(1);
        req   = 4'b0000;
        ready = 1'b1;

        // Reset mid-grant: the burst is dropped and requester 0 wins again.
        @(posedge clk);
        #1 req = 4'b1111;
        push(4'b0010, 2'd1, 2, 1, -1);
        push(4'b0001, 2'd0, 4, 3, -1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_falls(1);
        req = 4'b0000;

`ifdef RR_SEL_ARB_LOCK_EN
        // Lock held for 10 grant cycles; the count saturates at 3, then one beat releases.
        @(posedge clk);
        #1;
        req  = 4'b0100;
        lock = 1'b1;
        push(4'b0100, 2'd2, 10, 3, -1);
        repeat (10) @(posedge clk);
        #1 lock = 1'b0;
        wait_falls(1);
        req = 4'b0000;
`endif

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
